// File: rtl/ps2_scan_receiver_pkg.sv
// Shared constants, FSM encoding and parity helper for the PS/2 scan-code receiver.
package ps2_scan_receiver_pkg;

    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam logic [7:0] PS2_EXT = 8'hE0;

    localparam int FILT_DEFAULT    = 8;
    localparam int TW_DEFAULT      = 18;
    localparam int TIMEOUT_DEFAULT = 200000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    // PS/2 uses odd parity: the eight data bits plus the parity bit hold an odd count of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return (^data) ^ par;
    endfunction

endpackage

// File: rtl/ps2_scan_receiver_line_filter.sv
// Two-flop synchroniser plus FILT-sample glitch filter; emits the filtered level and a
// one-cycle strobe on each filtered 1->0 transition.
module ps2_line_filter
    import ps2_scan_receiver_pkg::*;
#(
    parameter int FILT = FILT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILT + 1);

    logic [1:0]    sync_r;
    logic [CW-1:0] cnt_r;
    logic          level_r;
    logic          fall_r;

    // Synchronise, then only accept a new level after FILT consecutive differing samples.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_r  <= 2'b11;
            cnt_r   <= {CW{1'b0}};
            level_r <= 1'b1;
            fall_r  <= 1'b0;
        end else begin
            sync_r <= {sync_r[0], line};
            fall_r <= 1'b0;
            if (sync_r[1] != level_r) begin
                if (cnt_r == CW'(FILT - 1)) begin
                    level_r <= sync_r[1];
                    cnt_r   <= {CW{1'b0}};
                    fall_r  <= level_r;
                end else begin
                    cnt_r <= cnt_r + CW'(1);
                end
            end else begin
                cnt_r <= {CW{1'b0}};
            end
        end
    end

    assign level = level_r;
    assign fall  = fall_r;

endmodule

// File: rtl/ps2_scan_receiver.sv
// Host-side PS/2 keyboard receiver: deserialises frames, filters E0/F0 prefixes and
// strobes make codes. Define PS2_RELEASE_EVT_EN to also report release codes on `rel`.
module ps2_scan_receiver
    import ps2_scan_receiver_pkg::*;
#(
    parameter int FILT    = FILT_DEFAULT,
    parameter int TW      = TW_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] Cambio,
    output logic       got_data,
    output logic       ext,
`ifdef PS2_RELEASE_EVT_EN
    output logic       rel,
`endif
    output logic       frame_err
);

    logic          clk_level_s;
    logic          fall_s;
    logic          data_s;
    logic [1:0]    data_sync_r;
    ps2_state_e    state_r;
    logic [7:0]    shift_r;
    logic [2:0]    bit_cnt_r;
    logic          par_r;
    logic [TW-1:0] tmo_r;
    logic          break_pend_r;
    logic          ext_pend_r;
    logic [7:0]    cambio_r;
    logic          got_data_r;
    logic          ext_r;
    logic          frame_err_r;
`ifdef PS2_RELEASE_EVT_EN
    logic          rel_r;
`endif

    ps2_line_filter #(.FILT(FILT)) u_clk_filter (
        .clk   (clk),
        .rst   (rst),
        .line  (ps2_clk),
        .level (clk_level_s),
        .fall  (fall_s)
    );

    // Data only needs synchronising: it is stable for many cycles around each clock fall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_sync_r <= 2'b11;
        end else begin
            data_sync_r <= {data_sync_r[0], ps2_data};
        end
    end

    assign data_s = data_sync_r[1];

    // Frame FSM, inactivity timeout, prefix tracking and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            shift_r      <= 8'h00;
            bit_cnt_r    <= 3'd0;
            par_r        <= 1'b0;
            tmo_r        <= {TW{1'b0}};
            break_pend_r <= 1'b0;
            ext_pend_r   <= 1'b0;
            cambio_r     <= 8'h00;
            got_data_r   <= 1'b0;
            ext_r        <= 1'b0;
            frame_err_r  <= 1'b0;
`ifdef PS2_RELEASE_EVT_EN
            rel_r        <= 1'b0;
`endif
        end else begin
            got_data_r  <= 1'b0;
            frame_err_r <= 1'b0;

            if (fall_s) begin
                tmo_r <= {TW{1'b0}};
            end else if (state_r != IDLE && tmo_r != TW'(TIMEOUT)) begin
                tmo_r <= tmo_r + TW'(1);
            end else begin
                tmo_r <= tmo_r;
            end

            if (fall_s) begin
                case (state_r)
                    IDLE: begin
                        if (!data_s) begin
                            state_r   <= DATA;
                            bit_cnt_r <= 3'd0;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    DATA: begin
                        shift_r   <= {data_s, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= PARITY;
                        end else begin
                            state_r <= DATA;
                        end
                    end
                    PARITY: begin
                        par_r   <= data_s;
                        state_r <= STOP;
                    end
                    STOP: begin
                        state_r <= IDLE;
                        if (!(odd_parity_ok(shift_r, par_r) && data_s)) begin
                            frame_err_r <= 1'b1;
                        end else if (shift_r == PS2_EXT) begin
                            ext_pend_r <= 1'b1;
                        end else if (shift_r == PS2_BRK) begin
                            break_pend_r <= 1'b1;
                        end else if (break_pend_r) begin
`ifdef PS2_RELEASE_EVT_EN
                            cambio_r   <= shift_r;
                            ext_r      <= ext_pend_r;
                            rel_r      <= 1'b1;
                            got_data_r <= 1'b1;
`endif
                            break_pend_r <= 1'b0;
                            ext_pend_r   <= 1'b0;
                        end else begin
                            cambio_r   <= shift_r;
                            ext_r      <= ext_pend_r;
                            got_data_r <= 1'b1;
                            ext_pend_r <= 1'b0;
`ifdef PS2_RELEASE_EVT_EN
                            rel_r      <= 1'b0;
`endif
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end else if (state_r != IDLE && tmo_r == TW'(TIMEOUT)) begin
                // Keyboard went quiet mid-frame: abandon it and forget any pending prefix.
                state_r      <= IDLE;
                bit_cnt_r    <= 3'd0;
                shift_r      <= 8'h00;
                frame_err_r  <= 1'b1;
                break_pend_r <= 1'b0;
                ext_pend_r   <= 1'b0;
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign Cambio    = cambio_r;
    assign got_data  = got_data_r;
    assign ext       = ext_r;
    assign frame_err = frame_err_r;
`ifdef PS2_RELEASE_EVT_EN
    assign rel       = rel_r;
`endif

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Self-checking bench for ps2_scan_receiver: drives PS/2 frames and compares the strobed
// events against a keypress-level reference model.
module tb_ps2_scan_receiver;

    localparam int FILT    = 8;
    localparam int TW      = 18;
    localparam int TIMEOUT = 300;
    localparam int HIGH_CY = 30;
    localparam int LOW_CY  = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] Cambio;
    logic       got_data;
    logic       ext;
    logic       frame_err;
    logic       rel_w;

    ps2_scan_receiver #(.FILT(FILT), .TW(TW), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .Cambio    (Cambio),
        .got_data  (got_data),
        .ext       (ext),
`ifdef PS2_RELEASE_EVT_EN
        .rel       (rel_w),
`endif
        .frame_err (frame_err)
    );

`ifndef PS2_RELEASE_EVT_EN
    assign rel_w = 1'b0;
`endif

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Observed events {rel, ext, code} and error pulses
    logic [9:0] got_q[$];
    int         err_seen = 0;

    // Reference model state
    logic [9:0] exp_q[$];
    int         err_exp = 0;
    bit         brk_m = 0;
    bit         ext_m = 0;
    logic [7:0] last_code_m = 8'h00;
    bit         last_ext_m = 0;
`ifdef PS2_RELEASE_EVT_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    always @(negedge clk) begin
        if (rst) begin
            if (got_data) got_q.push_back({rel_w, ext, Cambio});
            if (frame_err) err_seen++;
        end
    end

    task automatic model_frame(input logic [7:0] b, input bit bad);
        if (bad) begin
            err_exp++;
        end else if (b == 8'hE0) begin
            ext_m = 1;
        end else if (b == 8'hF0) begin
            brk_m = 1;
        end else if (brk_m) begin
            if (REL_EN) begin
                exp_q.push_back({1'b1, ext_m, b});
                last_code_m = b;
                last_ext_m = ext_m;
            end
            brk_m = 0;
            ext_m = 0;
        end else begin
            exp_q.push_back({1'b0, ext_m, b});
            last_code_m = b;
            last_ext_m = ext_m;
            ext_m = 0;
        end
    endtask

    task automatic model_reset();
        brk_m = 0;
        ext_m = 0;
        last_code_m = 8'h00;
        last_ext_m = 0;
    endtask

    // One PS/2 bit: data changes while clock is high, device pulls clock low for the sample.
    task automatic send_bit(input logic b, input bit glitch);
        @(negedge clk);
        ps2_data = b;
        repeat (14) @(negedge clk);
        if (glitch) begin
            ps2_clk = 1'b0;
            repeat (FILT - 1) @(negedge clk);
            ps2_clk = 1'b1;
        end else begin
            repeat (FILT - 1) @(negedge clk);
        end
        repeat (HIGH_CY - 14 - (FILT - 1)) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (LOW_CY) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit glitch, input int nbits);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(fr[i], glitch);
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (Cambio !== 8'h00) begin failures++; $display("FAIL reset_cambio: got %h expected 00", Cambio); end
        checks++; if (got_data !== 1'b0) begin failures++; $display("FAIL reset_got_data: got %b expected 0", got_data); end
        checks++; if (ext !== 1'b0) begin failures++; $display("FAIL reset_ext: got %b expected 0", ext); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (rel_w !== 1'b0) begin failures++; $display("FAIL reset_rel: got %b expected 0", rel_w); end
        rst = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_make();
        logic [9:0] ev, ex;
        send_frame(8'h75, 0, 0, 0, 11); model_frame(8'h75, 0);
        send_frame(8'h72, 0, 0, 0, 11); model_frame(8'h72, 0);
        send_frame(8'h72, 0, 0, 0, 11); model_frame(8'h72, 0);
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL make_count: got %0d events expected %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            ev = got_q.pop_front(); ex = exp_q.pop_front();
            checks++; if (ev !== ex) begin failures++; $display("FAIL make_event: got %h expected %h", ev, ex); end
        end
        got_q.delete(); exp_q.delete();
        checks++; if (err_seen !== err_exp) begin failures++; $display("FAIL make_err: got %0d expected %0d", err_seen, err_exp); end
    endtask

    task automatic test_release();
        logic [9:0] ev, ex;
        send_frame(8'hF0, 0, 0, 0, 11); model_frame(8'hF0, 0);
        send_frame(8'h75, 0, 0, 0, 11); model_frame(8'h75, 0);
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL release_count: got %0d events expected %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            ev = got_q.pop_front(); ex = exp_q.pop_front();
            checks++; if (ev !== ex) begin failures++; $display("FAIL release_event: got %h expected %h", ev, ex); end
        end
        got_q.delete(); exp_q.delete();
        checks++; if (Cambio !== last_code_m) begin failures++; $display("FAIL release_hold: got %h expected %h", Cambio, last_code_m); end
    endtask

    task automatic test_ext();
        logic [9:0] ev, ex;
        send_frame(8'hE0, 0, 0, 0, 11); model_frame(8'hE0, 0);
        send_frame(8'h75, 0, 0, 0, 11); model_frame(8'h75, 0);
        checks++; if (ext !== 1'b1) begin failures++; $display("FAIL ext_set: got %b expected 1", ext); end
        send_frame(8'h72, 0, 0, 0, 11); model_frame(8'h72, 0);
        checks++; if (ext !== 1'b0) begin failures++; $display("FAIL ext_clear: got %b expected 0", ext); end
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL ext_count: got %0d events expected %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            ev = got_q.pop_front(); ex = exp_q.pop_front();
            checks++; if (ev !== ex) begin failures++; $display("FAIL ext_event: got %h expected %h", ev, ex); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_frame_errors();
        send_frame(8'h73, 1, 0, 0, 11); model_frame(8'h73, 1);
        send_frame(8'h73, 0, 1, 0, 11); model_frame(8'h73, 1);
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL err_no_strobe: got %0d events expected 0", got_q.size()); end
        checks++; if (err_seen !== err_exp) begin failures++; $display("FAIL err_count: got %0d expected %0d", err_seen, err_exp); end
        checks++; if (Cambio !== last_code_m) begin failures++; $display("FAIL err_cambio_hold: got %h expected %h", Cambio, last_code_m); end
        got_q.delete();
    endtask

    task automatic test_timeout();
        logic [9:0] ev, ex;
        send_frame(8'hE0, 0, 0, 0, 11); model_frame(8'hE0, 0);
        send_frame(8'h72, 0, 0, 0, 5);
        repeat (TIMEOUT + 100) @(negedge clk);
        err_exp++; ext_m = 0; brk_m = 0;
        checks++; if (err_seen !== err_exp) begin failures++; $display("FAIL timeout_err: got %0d expected %0d", err_seen, err_exp); end
        send_frame(8'h72, 0, 0, 0, 11); model_frame(8'h72, 0);
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL timeout_count: got %0d events expected %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            ev = got_q.pop_front(); ex = exp_q.pop_front();
            checks++; if (ev !== ex) begin failures++; $display("FAIL timeout_event: got %h expected %h", ev, ex); end
        end
        got_q.delete(); exp_q.delete();
        checks++; if (err_seen !== err_exp) begin failures++; $display("FAIL timeout_err_once: got %0d expected %0d", err_seen, err_exp); end
    endtask

    task automatic test_glitch_and_reset();
        logic [9:0] ev, ex;
        send_frame(8'h6B, 0, 0, 1, 11); model_frame(8'h6B, 0);
        send_frame(8'hE0, 0, 0, 0, 11); model_frame(8'hE0, 0);
        send_frame(8'h74, 0, 0, 0, 4);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        checks++; if ({Cambio, got_data, ext, frame_err, rel_w} !== 12'h000) begin failures++; $display("FAIL midreset_outputs: got %h expected 000", {Cambio, got_data, ext, frame_err, rel_w}); end
        ps2_data = 1'b1;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h72, 0, 0, 0, 11); model_frame(8'h72, 0);
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL glitch_count: got %0d events expected %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            ev = got_q.pop_front(); ex = exp_q.pop_front();
            checks++; if (ev !== ex) begin failures++; $display("FAIL glitch_event: got %h expected %h", ev, ex); end
        end
        got_q.delete(); exp_q.delete();
        checks++; if (err_seen !== err_exp) begin failures++; $display("FAIL glitch_err: got %0d expected %0d", err_seen, err_exp); end
    endtask

    task automatic test_random();
        logic [9:0] ev, ex;
        logic [7:0] b;
        int sel, e;
        for (int n = 0; n < 24; n++) begin
            sel = $urandom_range(0, 9);
            b = (sel < 2) ? 8'hE0 : (sel < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
            e = $urandom_range(0, 9);
            send_frame(b, e == 0, e == 1, 0, 11);
            model_frame(b, e <= 1);
        end
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL random_count: got %0d events expected %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            ev = got_q.pop_front(); ex = exp_q.pop_front();
            checks++; if (ev !== ex) begin failures++; $display("FAIL random_event: got %h expected %h", ev, ex); end
        end
        got_q.delete(); exp_q.delete();
        checks++; if (err_seen !== err_exp) begin failures++; $display("FAIL random_err: got %0d expected %0d", err_seen, err_exp); end
        checks++; if ({ext, Cambio} !== {last_ext_m, last_code_m}) begin failures++; $display("FAIL random_hold: got %h expected %h", {ext, Cambio}, {last_ext_m, last_code_m}); end
    endtask

    initial begin
        test_reset();
        test_make();
        test_release();
        test_ext();
        test_frame_errors();
        test_timeout();
        test_glitch_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
